voice_mixer_pwm: RTL and testbench
==================================

# voice_mixer_pwm

Downstream output stage for the four speaker tone channels. Takes each voice's square-wave tone and its sequencer gate, applies a per-voice percussive decay envelope, sums the four weighted voices, and drives a single PWM audio pin plus a level readout for LEDs. It replaces driving one GPIO per speaker with one mixed output.

## Interface
- ENV_BITS, 8, envelope width per voice; mix width is ENV_BITS+2.
- DECAY_DIV, 196078, CLOCK_50 cycles per envelope decrement (≈1 s full decay at 50 MHz); legal range ≥ 2.
- CLOCK_50  input  1  system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- tone_in  input  4  square-wave tone per voice, synchronous to CLOCK_50.
- gate_in  input  4  note-on per voice from the step sequencer; a rising edge triggers the envelope.
- voice_en  input  4  per-voice output mute (0 = voice contributes 0).
- pwm_out  output  1  PWM audio, registered.
- level  output  ENV_BITS+2  mix value of the current PWM frame.
- active  output  4  active[i] = (env[i] != 0).

## Operation
- gate_q[3:0] registers gate_in; rise[i] = gate_in[i] & ~gate_q[i].
- Shared prescaler counts 0..DECAY_DIV-1 and wraps; tick asserts for the one cycle with count == DECAY_DIV-1.
- Per-voice env[i] (ENV_BITS):
  - If rise[i], load all-ones (255).
  - Else if tick and env[i] != 0, decrement by 1.
  - Otherwise hold. env saturates at 0 and never wraps.
  - rise wins over a simultaneous tick.
- Voice sample: s[i] = (tone_in[i] & voice_en[i]) ? env[i] : 0.
- mix_sum, registered every cycle = s0+s1+s2+s3, unsigned, ENV_BITS+2 bits. Max 1020, so no overflow.
- PWM counter: pwm_cnt counts 0..PWM_TOP and wraps, with PWM_TOP = 2^(ENV_BITS+2)-2 = 1022. Frame is 1023 cycles.
- mix_latched loads mix_sum on the cycle pwm_cnt == PWM_TOP, so a frame never changes mid-period.
- level = mix_latched.
- pwm_out registered: pwm_out <= (pwm_cnt < mix_latched). Gives exactly mix_latched high cycles per frame. 0 means always low; max 1020 leaves 3 low cycles.
- voice_en masks only the output. The envelope still triggers and decays, and active still reflects env.

## Timing
- Reset values: env, gate_q, prescaler, mix_sum, mix_latched, pwm_cnt all 0. pwm_out = 0, level = 0, active = 0.
- Reset is asynchronous: it takes effect immediately, mid-frame or mid-decay.
- After reset release, first rise is detected on the first edge where gate_in = 1.
- gate_in edge to env = 255: the same clock edge at which gate_in is first sampled high.
- env to mix_sum: 1 cycle.
- mix_sum to level: up to 1023 cycles (next frame boundary).
- level change to pwm_out: the frame starts 1 cycle after mix_latched loads (registered comparator).
- Full decay from 255 to 0 takes 255 ticks, i.e. 255·DECAY_DIV cycles worst case after the trigger.
- Retrigger mid-decay restarts at 255. The prescaler is not reset by a trigger.

## Configuration
- VOICE_ENVELOPE_EN defined: percussive decay envelope as described above.
- VOICE_ENVELOPE_EN undefined:
  - Prescaler and decay logic are removed.
  - env[i] is registered as gate_in[i] ? all-ones : 0, one cycle after gate_in.
  - Sustained tones follow the gate. rise is unused.

## Test plan
- Reset: assert reset mid-frame with pwm_out high -> pwm_out, level, active go to 0 immediately. Hold 2000 cycles -> pwm_out stays 0.
- Single voice: DECAY_DIV=4, tone_in=0001, gate0 rises -> env0 = 255. Next frame level = 255 and pwm_out is high 255 of 1023 cycles. active[0] drops after ≤ 1020 cycles.
- Full mix: DECAY_DIV large, all tone_in = 1, gate 0000→1111 -> level = 1020, pwm_out high 1020 / low 3 per frame.
- Mute: voice_en=1110, voice 0 triggered, tone0 = 1 -> level = 0, active[0] = 1 and env0 still decays.
- Retrigger: DECAY_DIV=4, env0 decayed to 100, gate0 re-rises on a tick cycle -> env0 = 255, no decrement that cycle.
- Macro off: gate0 = 1, tone0 = 1 -> level = 255 from the next frame and does not decay. gate0 = 0 -> level = 0 from the following frame.

Source files
------------

// File: rtl/voice_mixer_pwm.sv
// voice_mixer_pwm
// Mixes the four speaker tone channels into a single PWM audio pin.
// Each voice is weighted by an envelope value, the four weighted voices are
// summed, and the sum sets the duty cycle of a 1023-cycle PWM frame.
//
// Optional feature macro: VOICE_ENVELOPE_EN
//   defined   - a rising gate loads the voice envelope to full scale, and a
//               shared prescaler then decays it by one step per tick down to 0.
//   undefined - the envelope is simply full scale while the gate is high and 0
//               otherwise (sustained tones that follow the gate).
module voice_mixer_pwm #(
    parameter int ENV_BITS  = 8,
    parameter int DECAY_DIV = 196078
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [3:0]          tone_in,
    input  logic [3:0]          gate_in,
    input  logic [3:0]          voice_en,
    output logic                pwm_out,
    output logic [ENV_BITS+1:0] level,
    output logic [3:0]          active
);

    localparam int MIX_W = ENV_BITS + 2;

    // Last count of the PWM frame: 2^MIX_W - 2, so a frame is 2^MIX_W - 1
    // cycles long and a full-scale mix of four voices still leaves low time.
    localparam logic [MIX_W-1:0]    PWM_TOP  = {{(MIX_W-1){1'b1}}, 1'b0};
    localparam logic [ENV_BITS-1:0] ENV_FULL = '1;

    // A prescaler shorter than two cycles would make every cycle a tick.
    if (DECAY_DIV < 2) begin : g_bad_decay_div
        $error("voice_mixer_pwm: DECAY_DIV must be at least 2");
    end

    // Envelope step toward zero; holds at zero instead of wrapping.
    function automatic logic [ENV_BITS-1:0] env_decay(input logic [ENV_BITS-1:0] e);
        return (e == '0) ? e : e - ENV_BITS'(1);
    endfunction

    // Unsigned sum of four voice samples, widened so 4 * full scale fits.
    function automatic logic [MIX_W-1:0] mix4(input logic [3:0][ENV_BITS-1:0] s);
        logic [MIX_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            acc = acc + MIX_W'(s[i]);
        end
        return acc;
    endfunction

    logic [3:0][ENV_BITS-1:0] env_p0;
    logic [3:0][ENV_BITS-1:0] samp_p0;
    logic [MIX_W-1:0]         mix_sum_p1;
    logic [MIX_W-1:0]         mix_latched_p2;
    logic [MIX_W-1:0]         pwm_cnt;
    logic                     frame_end;

    // ---- stage 0: per-voice envelope ----
`ifdef VOICE_ENVELOPE_EN
    localparam int                PRE_W    = $clog2(DECAY_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DECAY_DIV - 1);

    logic [3:0]       gate_q;
    logic [3:0]       rise;
    logic [PRE_W-1:0] presc;
    logic             tick;

    assign rise = gate_in & ~gate_q;
    assign tick = (presc == PRE_LAST);

    // Previous gate level, used to find the note-on edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            gate_q <= '0;
        end else begin
            gate_q <= gate_in;
        end
    end

    // Free-running decay prescaler shared by all voices; triggers do not
    // restart it, so decay steps stay on a fixed global grid.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

    // Envelope: a note-on reloads full scale (winning over a same-cycle
    // tick), otherwise each tick steps the envelope toward zero.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            env_p0 <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rise[i]) begin
                    env_p0[i] <= ENV_FULL;
                end else if (tick) begin
                    env_p0[i] <= env_decay(env_p0[i]);
                end
            end
        end
    end
`else
    // Envelope follows the gate directly: full scale while held, else silent.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            env_p0 <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                env_p0[i] <= gate_in[i] ? ENV_FULL : '0;
            end
        end
    end
`endif

    // Voice samples: the envelope passes only while the tone is high and the
    // voice is enabled; muting never touches the envelope itself.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            samp_p0[i] = (tone_in[i] & voice_en[i]) ? env_p0[i] : '0;
        end
    end

    // Activity flags reflect the envelope, independent of tone or mute.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            active[i] = (env_p0[i] != '0);
        end
    end

    // ---- stage 1: four-voice mix ----
    // Registered sum of the weighted voices, refreshed every cycle.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            mix_sum_p1 <= '0;
        end else begin
            mix_sum_p1 <= mix4(samp_p0);
        end
    end

    // ---- stage 2: PWM frame ----
    assign frame_end = (pwm_cnt == PWM_TOP);

    // PWM frame counter 0..PWM_TOP.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else if (frame_end) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + MIX_W'(1);
        end
    end

    // Duty value is captured only at the frame boundary so a frame never
    // changes width part-way through.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            mix_latched_p2 <= '0;
        end else if (frame_end) begin
            mix_latched_p2 <= mix_sum_p1;
        end
    end

    // Registered comparator: exactly mix_latched_p2 high cycles per frame.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (pwm_cnt < mix_latched_p2);
        end
    end

    assign level = mix_latched_p2;

endmodule

// File: tb/tb_voice_mixer_pwm.sv
// Testbench for voice_mixer_pwm (ENV_BITS = 8, DECAY_DIV = 4).
// Works for both builds; the envelope-only scenarios sit under
// VOICE_ENVELOPE_EN. A reference model tracks edges since reset release and
// derives each envelope from the cycle of its last note-on in closed form.
module tb_voice_mixer_pwm;

    localparam int DIV     = 4;
    localparam int FRAME   = 1023;
    localparam int ENV_MAX = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tone = 4'b0000;
    logic [3:0] gate = 4'b0000;
    logic [3:0] en   = 4'b0000;
    logic       pwm_out;
    logic [9:0] level;
    logic [3:0] active;

    int errors = 0;
    int checks = 0;

    voice_mixer_pwm #(
        .ENV_BITS (8),
        .DECAY_DIV(DIV)
    ) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .tone_in (tone),
        .gate_in (gate),
        .voice_en(en),
        .pwm_out (pwm_out),
        .level   (level),
        .active  (active)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_cyc is the index of the next rising edge since reset release.
    int       m_cyc;
    int       m_rise [4];
    int       m_env  [4];
    int       m_mix;
    int       m_ml;
    bit       m_pwm;
    bit [3:0] m_gq;
    bit [3:0] m_active;
    int       m_new_mix;
    int       m_ticks;

    always @(posedge clk) begin
        if (rst) begin
            m_cyc = 0; m_mix = 0; m_ml = 0; m_pwm = 0; m_gq = '0; m_active = '0;
            for (int i = 0; i < 4; i++) begin
                m_rise[i] = -1;
                m_env[i]  = 0;
            end
        end else begin
            m_new_mix = 0;
            for (int i = 0; i < 4; i++) begin
                if (tone[i] && en[i]) m_new_mix += m_env[i];
            end
            m_pwm = ((m_cyc % FRAME) < m_ml);
            if ((m_cyc % FRAME) == FRAME - 1) m_ml = m_mix;
            m_mix = m_new_mix;
            for (int i = 0; i < 4; i++) begin
`ifdef VOICE_ENVELOPE_EN
                if (gate[i] && !m_gq[i]) m_rise[i] = m_cyc;
                if (m_rise[i] < 0) begin
                    m_env[i] = 0;
                end else begin
                    // ticks land on edges k with k % DIV == DIV-1
                    m_ticks  = (m_cyc + 1) / DIV - (m_rise[i] + 1) / DIV;
                    m_env[i] = (m_ticks >= ENV_MAX) ? 0 : ENV_MAX - m_ticks;
                end
`else
                m_env[i] = gate[i] ? ENV_MAX : 0;
`endif
                m_active[i] = (m_env[i] != 0);
            end
            m_gq = gate;
            m_cyc++;
        end
    end

    // Advance to the negedge where the next edge index is val modulo modv.
    task automatic wait_phase(input int modv, input int val);
        for (int k = 0; k <= modv; k++) begin
            if ((m_cyc % modv) == val) return;
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int hi;
        bit seen;
        repeat (3) @(negedge clk);
        checks++; if (pwm_out !== 1'b0)   begin errors++; $display("FAIL reset_pwm: got %0b want 0", pwm_out); end
        checks++; if (level !== 10'd0)    begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (active !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b want 0000", active); end
        rst = 1'b0;
        tone = 4'b1111; en = 4'b1111; gate = 4'b0000;
        wait_phase(FRAME, FRAME - 3);
        gate = 4'b1111;
        seen = 0;
        for (int k = 0; k < 2200 && !seen; k++) begin
            @(negedge clk);
            if (pwm_out === 1'b1) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL reset_pwm_high_timeout: got pwm never high, want high within 2200 cycles"); end
        repeat (50) @(negedge clk);
        checks++; if (pwm_out !== 1'b1) begin errors++; $display("FAIL reset_pre_pwm: got %0b want 1", pwm_out); end
        #2 rst = 1'b1;
        #1;
        checks++; if (pwm_out !== 1'b0)   begin errors++; $display("FAIL reset_async_pwm: got %0b want 0", pwm_out); end
        checks++; if (level !== 10'd0)    begin errors++; $display("FAIL reset_async_level: got %0d want 0", level); end
        checks++; if (active !== 4'b0000) begin errors++; $display("FAIL reset_async_active: got %b want 0000", active); end
        hi = 0;
        repeat (2000) begin
            @(negedge clk);
            hi += int'(pwm_out);
        end
        checks++; if (hi !== 0) begin errors++; $display("FAIL reset_hold_pwm: got %0d high cycles want 0", hi); end
        tone = 4'b0000; gate = 4'b0000; en = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_voice();
        int hi;
        tone = 4'b0001; en = 4'b1111; gate = 4'b0000;
        repeat (4) @(negedge clk);
        wait_phase(FRAME, FRAME - 3);
        gate = 4'b0001;
        @(negedge clk);
        checks++; if (active !== 4'b0001) begin errors++; $display("FAIL single_active_on: got %b want 0001", active); end
        wait_phase(FRAME, 0);
        checks++; if (level !== 10'd255) begin errors++; $display("FAIL single_level: got %0d want 255", level); end
        hi = 0;
        repeat (FRAME) begin
            @(negedge clk);
            hi += int'(pwm_out);
            checks++; if (active !== m_active) begin errors++; $display("FAIL single_active_track: got %b want %b", active, m_active); end
        end
        checks++; if (hi !== 255) begin errors++; $display("FAIL single_duty: got %0d high cycles want 255", hi); end
`ifdef VOICE_ENVELOPE_EN
        checks++; if (active[0] !== 1'b0) begin errors++; $display("FAIL single_decayed: got active0=%0b want 0", active[0]); end
`else
        checks++; if (level !== 10'd255) begin errors++; $display("FAIL single_sustain: got %0d want 255", level); end
        wait_phase(FRAME, FRAME - 3);
        gate = 4'b0000;
        wait_phase(FRAME, 0);
        checks++; if (level !== 10'd0) begin errors++; $display("FAIL single_release: got %0d want 0", level); end
`endif
        gate = 4'b0000;
    endtask

    task automatic test_full_mix();
        int hi;
        tone = 4'b1111; en = 4'b1111; gate = 4'b0000;
        repeat (4) @(negedge clk);
        wait_phase(FRAME, FRAME - 3);
        gate = 4'b1111;
        wait_phase(FRAME, 0);
        checks++; if (level !== 10'd1020) begin errors++; $display("FAIL mix_level: got %0d want 1020", level); end
        hi = 0;
        repeat (FRAME) begin
            @(negedge clk);
            hi += int'(pwm_out);
        end
        checks++; if (hi !== 1020) begin errors++; $display("FAIL mix_duty: got %0d high cycles want 1020", hi); end
        gate = 4'b0000;
    endtask

    task automatic test_mute();
        tone = 4'b0001; en = 4'b1110; gate = 4'b0000;
        repeat (4) @(negedge clk);
        wait_phase(FRAME, FRAME - 3);
        gate = 4'b0001;
        wait_phase(FRAME, 0);
        checks++; if (level !== 10'd0)    begin errors++; $display("FAIL mute_level: got %0d want 0", level); end
        checks++; if (active[0] !== 1'b1) begin errors++; $display("FAIL mute_active: got %0b want 1", active[0]); end
`ifdef VOICE_ENVELOPE_EN
        repeat (1100) @(negedge clk);
        checks++; if (active[0] !== 1'b0) begin errors++; $display("FAIL mute_decay: got active0=%0b want 0", active[0]); end
`endif
        gate = 4'b0000; en = 4'b1111;
    endtask

`ifdef VOICE_ENVELOPE_EN
    // Retrigger lands on edge 2043 mod 4092: a tick edge (2043 % 4 == 3) that
    // is also two edges before a frame boundary, so the next level shows the
    // envelope exactly as left by that edge. The first trigger 620 edges
    // earlier leaves the envelope one tick away from 100.
    task automatic test_retrigger();
        tone = 4'b0001; en = 4'b1111; gate = 4'b0000;
        repeat (4) @(negedge clk);
        wait_phase(4 * FRAME, 1423);
        gate = 4'b0001;
        repeat (8) @(negedge clk);
        gate = 4'b0000;
        wait_phase(4 * FRAME, 2043);
        gate = 4'b0001;
        @(negedge clk);
        checks++; if (active[0] !== 1'b1) begin errors++; $display("FAIL retrig_active: got %0b want 1", active[0]); end
        wait_phase(FRAME, 0);
        checks++; if (level !== 10'd255) begin errors++; $display("FAIL retrig_level: got %0d want 255", level); end
        gate = 4'b0000;
    endtask
`endif

    task automatic test_random();
        tone = 4'($urandom); gate = 4'b0000; en = 4'b1111;
        repeat (3000) begin
            @(negedge clk);
            checks++; if (pwm_out !== m_pwm)      begin errors++; $display("FAIL rand_pwm: cyc %0d got %0b want %0b", m_cyc, pwm_out, m_pwm); end
            checks++; if (level !== 10'(m_ml))    begin errors++; $display("FAIL rand_level: cyc %0d got %0d want %0d", m_cyc, level, m_ml); end
            checks++; if (active !== m_active)    begin errors++; $display("FAIL rand_active: cyc %0d got %b want %b", m_cyc, active, m_active); end
            tone = 4'($urandom);
            if ($urandom_range(0, 15) == 0) gate = gate ^ 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 255) == 0) en = 4'($urandom);
        end
    endtask

    initial begin
        test_reset();
        test_single_voice();
        test_full_mix();
        test_mute();
`ifdef VOICE_ENVELOPE_EN
        test_retrigger();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
